// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and frame layout.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    localparam int HDR_LEN = 2;

endpackage

// File: rtl/rom_loader.sv
// Loads a framed, checksummed byte stream into the instruction ROM write port
// and releases the core with go once the frame checksum verifies.
module rom_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              go,
    output logic              load_err,
    output logic              busy
);

    // Word counts are kept 17 bits wide so that N == DEPTH (up to 2^16) is representable.
    localparam logic [16:0] DEPTH = 17'(32'd1 << ADDR_W);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [16:0] n_words;
    logic [16:0] word_idx;
    logic [7:0]  len_lo;
    logic [7:0]  csum_acc;
    logic [23:0] lane_buf;
    logic        accept;
    logic [16:0] len_rx;

    assign accept   = in_valid && in_ready;
    assign len_rx   = {1'b0, in_data, len_lo};
    assign in_ready = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    assign busy     = in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            n_words   <= '0;
            word_idx  <= '0;
            len_lo    <= '0;
            csum_acc  <= '0;
            lane_buf  <= '0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            go        <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            rom_we <= 1'b0;
            if (accept && state != CSUM) begin
                csum_acc <= csum_acc ^ in_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LEN0;
                    end
                end
                LEN0: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        n_words <= len_rx;
                        if (len_rx > DEPTH) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else if (len_rx == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        // Bytes arrive LSB first, so shifting right leaves byte 0 in the low lane.
                        if (byte_cnt == 2'd3) begin
                            rom_we    <= 1'b1;
                            rom_addr  <= word_idx[ADDR_W-1:0];
                            rom_wdata <= {in_data, lane_buf};
                            word_idx  <= word_idx + 17'd1;
                            if (word_idx + 17'd1 == n_words) begin
                                state <= CSUM;
                            end
                        end else begin
                            lane_buf <= {in_data, lane_buf[23:8]};
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (in_data == csum_acc) begin
                            state <= DONE;
                            go    <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a frame-position model predicts every output
// each cycle, and literal expectations pin the nominal, error and reset cases.
module tb_rom_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;
    logic              go;
    logic              load_err;
    logic              busy;

    rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .go        (go),
        .load_err  (load_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: tracks position in the frame and derives outputs from the frame rules.
    bit          m_started = 0;
    bit          m_active  = 0;
    bit          m_go      = 0;
    bit          m_err     = 0;
    bit          m_we      = 0;
    int          m_addr    = 0;
    logic [31:0] m_wdata   = '0;
    logic [7:0]  q[$];

    always @(posedge clk) begin
        int p;
        int n;
        logic [7:0] x;
        m_we = 0;
        if (reset) begin
            m_started = 0; m_active = 0; m_go = 0; m_err = 0;
            q.delete();
        end else if (!m_started) begin
            if (start) begin
                m_started = 1;
                m_active  = 1;
            end
        end else if (m_active && in_valid) begin
            p = q.size();
            q.push_back(in_data);
            n = (p >= 1) ? int'(q[1]) * 256 + int'(q[0]) : 0;
            if (p == 1) begin
                if (n > DEPTH) begin
                    m_err = 1; m_active = 0;
                end
            end
            if (p >= 2 && p < 2 + 4 * n) begin
                if ((p - 2) % 4 == 3) begin
                    m_we    = 1;
                    m_addr  = (p - 2) / 4;
                    m_wdata = {q[p], q[p-1], q[p-2], q[p-3]};
                end
            end else if (p >= 2 && p == 2 + 4 * n) begin
                x = 8'h00;
                for (int i = 0; i < p; i++) x = x ^ q[i];
                if (in_data == x) m_go = 1;
                else m_err = 1;
                m_active = 0;
            end
        end
    end

    int          log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_active));
            chk("busy", 32'(busy), 32'(m_active));
            chk("rom_we", 32'(rom_we), 32'(m_we));
            if (m_we) begin
                chk("rom_addr", 32'(rom_addr), 32'(m_addr));
                chk("rom_wdata", rom_wdata, m_wdata);
            end
            chk("go", 32'(go), 32'(m_go));
            chk("load_err", 32'(load_err), 32'(m_err));
            if (rom_we) begin
                log_addr.push_back(int'(rom_addr));
                log_data.push_back(rom_wdata);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick(1);
        reset = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input bit gaps);
        foreach (bytes[i]) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'hA5;
                tick(1);
            end
            in_valid = 1'b1;
            in_data  = bytes[i];
            tick(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_rom_we"}, 32'(rom_we), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_rom_wdata"}, rom_wdata, 32'd0);
        chk({tag, "_go"}, 32'(go), 32'd0);
        chk({tag, "_load_err"}, 32'(load_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_nominal_writes(input string tag);
        chk({tag, "_nwrites"}, 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk({tag, "_addr0"}, 32'(log_addr[0]), 32'd0);
            chk({tag, "_data0"}, log_data[0], 32'h00500093);
            chk({tag, "_addr1"}, 32'(log_addr[1]), 32'd1);
            chk({tag, "_data1"}, log_data[1], 32'h00108133);
        end
    endtask

    logic [7:0] nominal[$];
    logic [7:0] bad[$];
    logic [7:0] frame[$];

    initial begin
        nominal = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h63};
        bad     = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h62};

        tick(2);
        chk_en = 1'b1;
        check_reset_vals("por");

        // Nominal load
        do_reset();
        pulse_start();
        chk("start_ready", 32'(in_ready), 32'd1);
        send_frame(nominal, 1'b0);
        chk("nom_go_next", 32'(go), 32'd1);
        tick(3);
        check_nominal_writes("nom");
        chk("nom_err", 32'(load_err), 32'd0);
        pulse_start();
        tick(2);
        chk("nom_done_ready", 32'(in_ready), 32'd0);

        // Bad checksum
        do_reset();
        pulse_start();
        send_frame(bad, 1'b0);
        tick(3);
        check_nominal_writes("bad");
        chk("bad_err", 32'(load_err), 32'd1);
        chk("bad_go", 32'(go), 32'd0);
        chk("bad_ready", 32'(in_ready), 32'd0);

        // Empty program
        do_reset();
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(frame, 1'b0);
        tick(2);
        chk("empty_go", 32'(go), 32'd1);
        chk("empty_nwrites", 32'(log_addr.size()), 32'd0);

        // Oversize length, followed by bytes that must be ignored
        do_reset();
        pulse_start();
        frame = '{8'h01, 8'h04};
        send_frame(frame, 1'b0);
        chk("over_err_next", 32'(load_err), 32'd1);
        chk("over_ready", 32'(in_ready), 32'd0);
        frame = '{8'h93, 8'h00, 8'h50, 8'h00};
        send_frame(frame, 1'b0);
        tick(2);
        chk("over_nwrites", 32'(log_addr.size()), 32'd0);
        chk("over_go", 32'(go), 32'd0);

        // Exactly DEPTH words is accepted as a length (no error after LEN_HI)
        do_reset();
        pulse_start();
        frame = '{8'h00, 8'h04};
        send_frame(frame, 1'b0);
        chk("depth_ok_err", 32'(load_err), 32'd0);
        chk("depth_ok_ready", 32'(in_ready), 32'd1);

        // Backpressure gaps
        do_reset();
        pulse_start();
        send_frame(nominal, 1'b1);
        chk("gap_go_next", 32'(go), 32'd1);
        tick(2);
        check_nominal_writes("gap");

        // start together with reset: reset wins
        reset = 1'b1; start = 1'b1;
        tick(1);
        reset = 1'b0; start = 1'b0;
        tick(1);
        check_reset_vals("rst_start");
        log_addr.delete();
        log_data.delete();

        // Reset after byte 5, then a fresh load
        pulse_start();
        frame = nominal[0:4];
        send_frame(frame, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_reset_vals("mid");
        log_addr.delete();
        log_data.delete();
        pulse_start();
        send_frame(nominal, 1'b0);
        tick(2);
        check_nominal_writes("mid_reload");
        chk("mid_reload_go", 32'(go), 32'd1);

        // Reset coinciding with the 4th data byte: no write may appear
        do_reset();
        pulse_start();
        frame = nominal[0:4];
        send_frame(frame, 1'b0);
        reset = 1'b1; in_valid = 1'b1; in_data = nominal[5];
        tick(1);
        reset = 1'b0; in_valid = 1'b0;
        check_reset_vals("inflight");
        tick(2);
        chk("inflight_nwrites", 32'(log_addr.size()), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
